// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, instruction
// field layout and the issue FSM state encoding.
package alu_pkg;

  localparam int SIZE_DEF  = 32;
  localparam int NREGS_DEF = 8;
  localparam int RADDR_W   = 3;

  // Op codes double as the ALU select value.
  localparam logic [2:0] OP_NOT = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  // Instruction field offsets (each field is 3 bits wide).
  localparam int OP_LSB = 9;
  localparam int RD_LSB = 6;
  localparam int RA_LSB = 3;
  localparam int RB_LSB = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Split a raw 12-bit instruction word into its fields.
  function automatic instr_t decode_instr(input logic [11:0] raw);
    instr_t f;
    f.op = raw[OP_LSB +: 3];
    f.rd = raw[RD_LSB +: 3];
    f.ra = raw[RA_LSB +: 3];
    f.rb = raw[RB_LSB +: 3];
    return f;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x SIZE register file: one write port, two operand read ports that
// the issue FSM samples in READ, and a combinational debug read port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [RADDR_W-1:0]   i_waddr,
  input  logic [SIZE-1:0]      i_wdata,
  input  logic [RADDR_W-1:0]   i_ra_addr,
  output logic [SIZE-1:0]      o_ra_data,
  input  logic [RADDR_W-1:0]   i_rb_addr,
  output logic [SIZE-1:0]      o_rb_data,
  input  logic [RADDR_W-1:0]   i_dbg_addr,
  output logic [SIZE-1:0]      o_dbg_data
);

  logic [SIZE-1:0] r_mem [NREGS];

  // Storage: cleared asynchronously, single write port otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= {SIZE{1'b0}};
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: accepts instructions over
// valid/ready, fetches operands, drives the ALU, writes results back and
// pulses done (or err for the illegal opcode). One instruction per 4 cycles.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [11:0]        instr,
  input  logic               load_en,
  input  logic [2:0]         load_addr,
  input  logic [SIZE-1:0]    load_data,
  input  logic [2:0]         dbg_addr,
  output logic [SIZE-1:0]    dbg_data,
  output logic [SIZE-1:0]    alu_a,
  output logic [SIZE-1:0]    alu_b,
  output logic [2:0]         alu_select,
  input  logic [SIZE-1:0]    alu_result,
  input  logic               alu_c_out,
  output logic               c_flag,
  output logic               done,
  output logic               err
);

  state_t          r_state;
  state_t          w_next_state;
  instr_t          r_instr;
  instr_t          w_dec;
  logic [SIZE-1:0] r_alu_a;
  logic [SIZE-1:0] r_alu_b;
  logic [2:0]      r_alu_sel;
  logic            r_c_flag;
  logic            r_done;
  logic            r_err;

  logic            w_idle;
  logic            w_load;
  logic            w_accept;
  logic            w_we;
  logic [2:0]      w_waddr;
  logic [SIZE-1:0] w_wdata;
  logic [SIZE-1:0] w_ra_data;
  logic [SIZE-1:0] w_rb_data;

  assign w_idle   = (r_state == ST_IDLE);
  // Preload wins over accept, and only counts while idle.
  assign w_load   = w_idle & load_en;
  assign w_accept = w_idle & ~load_en & instr_valid;
  assign w_dec    = decode_instr(instr);

  // Ready is held low during reset so nothing is accepted while clearing.
  assign instr_ready = rst_n & w_idle & ~load_en;

  // Next-state sequencing of the fixed four-phase issue loop.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  begin
        if (w_accept) begin
          w_next_state = ST_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ:  w_next_state = ST_EXEC;
      ST_EXEC:  w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Regfile write port: preload in IDLE, writeback in WRITE for legal ops.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = load_addr;
    w_wdata = load_data;
    if (w_load) begin
      w_we = 1'b1;
    end else if ((r_state == ST_WRITE) && (r_instr.op != OP_ILL)) begin
      w_we    = 1'b1;
      w_waddr = r_instr.rd;
      w_wdata = alu_result;
    end else begin
      w_we = 1'b0;
    end
  end

  alu_regfile #(
    .SIZE  (SIZE),
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_ra_addr  (r_instr.ra),
    .o_ra_data  (w_ra_data),
    .i_rb_addr  (r_instr.rb),
    .o_rb_data  (w_rb_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // FSM state register; reset mid-instruction simply drops back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the instruction fields on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '{op: 3'd0, rd: 3'd0, ra: 3'd0, rb: 3'd0};
    end else if (w_accept) begin
      r_instr <= w_dec;
    end
  end

  // ALU drive registers change only in READ so the ALU never sees glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= {SIZE{1'b0}};
      r_alu_b   <= {SIZE{1'b0}};
      r_alu_sel <= 3'd0;
    end else if (r_state == ST_READ) begin
      r_alu_a   <= w_ra_data;
      r_alu_b   <= w_rb_data;
      r_alu_sel <= r_instr.op;
    end
  end

  // Retire: done/err pulses and the sticky carry taken from ADD only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_flag <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == ST_WRITE) begin
        if (r_instr.op == OP_ILL) begin
          r_err <= 1'b1;
        end else begin
          r_done <= 1'b1;
          if (r_instr.op == OP_ADD) begin
            r_c_flag <= alu_c_out;
          end
        end
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_select = r_alu_sel;
  assign c_flag     = r_c_flag;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU alongside the DUT, a
// transaction-level reference model, a per-cycle compare process, directed
// scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_ctrl;
  localparam int SIZE = 32;

  logic            clk;
  logic            rst_n;
  logic            instr_valid;
  logic            instr_ready;
  logic [11:0]     instr;
  logic            load_en;
  logic [2:0]      load_addr;
  logic [SIZE-1:0] load_data;
  logic [2:0]      dbg_addr;
  logic [SIZE-1:0] dbg_data;
  logic [SIZE-1:0] alu_a;
  logic [SIZE-1:0] alu_b;
  logic [2:0]      alu_select;
  logic [SIZE-1:0] alu_result;
  logic            alu_c_out;
  logic            c_flag;
  logic            done;
  logic            err;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.SIZE(SIZE), .NREGS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_select  (alu_select),
    .alu_result  (alu_result),
    .alu_c_out   (alu_c_out),
    .c_flag      (c_flag),
    .done        (done),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational ALU the controller drives.
  logic [SIZE:0] tb_sum;
  always_comb begin
    tb_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_c_out = tb_sum[SIZE];
    case (alu_select)
      3'd0:    alu_result = ~alu_a;
      3'd1:    alu_result = alu_a;
      3'd2:    alu_result = alu_a | alu_b;
      3'd3:    alu_result = alu_a & alu_b;
      3'd4:    alu_result = alu_a + ~alu_b + 32'd1;
      3'd5:    alu_result = tb_sum[SIZE-1:0];
      3'd6:    alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 32'd0;
    endcase
  end

  // Reference semantics of one instruction.
  function automatic logic [SIZE-1:0] ref_result(input logic [2:0] op, input logic [SIZE-1:0] a,
                                                 input logic [SIZE-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a;
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return a - b;
      3'd5:    return a + b;
      3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic [SIZE-1:0] m_regs [8];
  logic            m_c;
  int              m_busy;      // edges remaining until the instruction retires
  logic [11:0]     m_pend;
  logic            m_done;
  logic            m_err;
  logic [SIZE-1:0] m_a;
  logic [SIZE-1:0] m_b;
  logic [2:0]      m_sel;
  logic [SIZE:0]   m_wide;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_c = 1'b0; m_busy = 0; m_pend = 12'd0; m_done = 1'b0; m_err = 1'b0;
        m_a = 32'd0; m_b = 32'd0; m_sel = 3'd0;
      end else begin
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_busy == 0) begin
          if (load_en) m_regs[load_addr] = load_data;
          else if (instr_valid) begin
            m_pend = instr;
            m_busy = 3;
          end
        end else begin
          if (m_busy == 3) begin
            m_a   = m_regs[m_pend[5:3]];
            m_b   = m_regs[m_pend[2:0]];
            m_sel = m_pend[11:9];
          end
          if (m_busy == 1) begin
            if (m_pend[11:9] == 3'd7) m_err = 1'b1;
            else begin
              m_wide = {1'b0, m_regs[m_pend[5:3]]} + {1'b0, m_regs[m_pend[2:0]]};
              if (m_pend[11:9] == 3'd5) m_c = m_wide[SIZE];
              m_regs[m_pend[8:6]] = ref_result(m_pend[11:9], m_regs[m_pend[5:3]],
                                               m_regs[m_pend[2:0]]);
              m_done = 1'b1;
            end
          end
          m_busy = m_busy - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, (m_busy == 0) && !load_en});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("c_flag", {31'd0, c_flag}, {31'd0, m_c});
        chk("dbg_data", dbg_data, m_regs[dbg_addr]);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_select", {29'd0, alu_select}, {29'd0, m_sel});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [2:0] a, input logic [SIZE-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Issue one instruction; returns in the cycle where done/err is high.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb);
    instr_valid = 1'b1; instr = {op, rd, ra, rb};
    step();
    instr_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_reg(input string name, input logic [2:0] idx, input logic [SIZE-1:0] exp);
    dbg_addr = idx;
    #1;
    chk(name, dbg_data, exp);
    chk({"model_", name}, m_regs[idx], exp);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 12'd0; load_en = 1'b0;
    load_addr = 3'd0; load_data = 32'd0; dbg_addr = 3'd0;
    repeat (3) step();
    #1 chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);
    step();

    // ADD with carry out
    preload(3'd1, 32'hFFFF_FFFF);
    preload(3'd2, 32'h0000_0001);
    issue(3'd5, 3'd3, 3'd1, 3'd2);
    chk("add_done", {31'd0, done}, 32'd1);
    check_reg("add_r3", 3'd3, 32'h0000_0000);
    chk("add_carry", {31'd0, c_flag}, 32'd1);

    // ADD then SUB: SUB borrow never reaches c_flag
    preload(3'd1, 32'd5);
    preload(3'd2, 32'd7);
    issue(3'd5, 3'd4, 3'd1, 3'd2);
    check_reg("add_r4", 3'd4, 32'h0000_000C);
    chk("add_nocarry", {31'd0, c_flag}, 32'd0);
    issue(3'd4, 3'd5, 3'd1, 3'd2);
    check_reg("sub_r5", 3'd5, 32'hFFFF_FFFE);
    chk("sub_c_hold", {31'd0, c_flag}, 32'd0);

    // Dependent chain issued on the done cycle
    preload(3'd1, 32'hA5A5_A5A5);
    issue(3'd1, 3'd6, 3'd1, 3'd0);
    chk("mov_done", {31'd0, done}, 32'd1);
    chk("ready_on_done", {31'd0, instr_ready}, 32'd1);
    issue(3'd0, 3'd7, 3'd6, 3'd0);
    check_reg("chain_r6", 3'd6, 32'hA5A5_A5A5);
    check_reg("chain_r7", 3'd7, 32'h5A5A_5A5A);

    // Illegal opcode
    preload(3'd2, 32'h0000_1234);
    issue(3'd7, 3'd2, 3'd0, 3'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_nodone", {31'd0, done}, 32'd0);
    check_reg("ill_r2", 3'd2, 32'h0000_1234);
    chk("ill_c_hold", {31'd0, c_flag}, 32'd0);
    step();
    chk("ill_err_pulse", {31'd0, err}, 32'd0);

    // Preload beats a simultaneous valid; instruction taken next cycle
    load_en = 1'b1; load_addr = 3'd0; load_data = 32'h0000_DEAD;
    instr_valid = 1'b1; instr = {3'd2, 3'd0, 3'd0, 3'd2};
    #1 chk("ready_under_load", {31'd0, instr_ready}, 32'd0);
    step();
    load_en = 1'b0;
    #1 chk("ready_after_load", {31'd0, instr_ready}, 32'd1);
    step();
    instr_valid = 1'b0;
    repeat (3) step();
    check_reg("or_r0", 3'd0, 32'h0000_DEBD);

    // Preload during EXEC is ignored
    instr_valid = 1'b1; instr = {3'd3, 3'd5, 3'd1, 3'd1};
    step();
    instr_valid = 1'b0;
    step();
    load_en = 1'b1; load_addr = 3'd4; load_data = 32'h1111_1111;
    step();
    load_en = 1'b0;
    step();
    check_reg("exec_load_r4", 3'd4, 32'h0000_000C);
    check_reg("and_r5", 3'd5, 32'hA5A5_A5A5);

    // Reset asserted mid-EXEC aborts the instruction
    instr_valid = 1'b1; instr = {3'd5, 3'd3, 3'd1, 3'd1};
    step();
    instr_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) check_reg("rst_clear", i[2:0], 32'd0);
    chk("rst_nodone", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1 chk("ready_release", {31'd0, instr_ready}, 32'd1);
    step();
    repeat (4) begin
      chk("abort_nodone", {31'd0, done}, 32'd0);
      step();
    end

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      instr_valid = ($urandom_range(0, 1) == 1);
      instr       = 12'($urandom);
      load_en     = ($urandom_range(0, 4) == 0);
      load_addr   = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       load_data = 32'h0000_0000;
        1:       load_data = 32'hFFFF_FFFF;
        2:       load_data = 32'h8000_0000;
        default: load_data = $urandom;
      endcase
      dbg_addr = 3'($urandom);
      step();
    end
    instr_valid = 1'b0;
    load_en     = 1'b0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
